// File: rtl/mem_stall_arb_if.sv
// Request/grant bus between the pipeline requesters, the shared memory
// controller and the stall arbiter.
//   req       : per-port level request from the pipeline stages
//   mem_done  : completion from the shared memory controller
//   grant     : one-hot memory mux select from the arbiter
//   mem_start : one-cycle start pulse for the controller
//   port_done : one-hot completion pulse back to the requesting stage
//   hold      : global pipeline stall
// Modport master = requester/controller side, slave = arbiter side.
interface mem_stall_arb_if #(
  parameter int NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] port_done;
  logic                 mem_start;
  logic                 mem_done;
  logic                 hold;

  modport master (
    output req, mem_done,
    input  grant, mem_start, port_done, hold
  );

  modport slave (
    input  req, mem_done,
    output grant, mem_start, port_done, hold
  );
endinterface

// File: rtl/mem_stall_arb.sv
// Memory-stall controller and shared-memory arbiter.
// Serialises up to NUM_PORTS pipeline requesters (lower index = higher
// priority) onto one memory controller and stalls the pipeline until every
// request of the current slot has completed. An optional per-access timeout
// force-completes a hung access and sets a sticky error flag.
// Ports:
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   initializing : boot in progress; suppresses hold and new grants
//   bus          : request/grant bus (slave modport)
//   timeout_err  : sticky timeout flag, cleared only by reset
module mem_stall_arb #(
  parameter int NUM_PORTS = 2,
  parameter int WAIT_W    = 4,
  parameter int TIMEOUT   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  initializing,
  mem_stall_arb_if.slave        bus,
  output logic                  timeout_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_reg, state_next;
  logic [NUM_PORTS-1:0]  grant_reg, grant_next;
  logic [NUM_PORTS-1:0]  served_reg, served_next;
  logic                  mem_start_reg, mem_start_next;
  logic [WAIT_W-1:0]     wait_cnt_reg, wait_cnt_next;
  logic                  timeout_err_reg, timeout_err_next;

  logic [NUM_PORTS-1:0]  pending, remaining, done_now;
  logic [NUM_PORTS-1:0]  pending_first, remaining_first;
  logic [NUM_PORTS-1:0]  pending_below, remaining_below;
  logic                  busy, timeout_hit, done_evt, hold_int;

  assign pending = bus.req & ~served_reg;

  // Lowest-index one-hot pick: *_below[i] is set when any lower port is set.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_pick
    if (gi == 0) begin : g_first
      assign pending_below[gi]   = 1'b0;
      assign remaining_below[gi] = 1'b0;
    end else begin : g_rest
      assign pending_below[gi]   = pending_below[gi-1]   | pending[gi-1];
      assign remaining_below[gi] = remaining_below[gi-1] | remaining[gi-1];
    end
    assign pending_first[gi]   = pending[gi]   & ~pending_below[gi];
    assign remaining_first[gi] = remaining[gi] & ~remaining_below[gi];
  end

  always_comb begin
    busy        = (state_reg == BUSY);
    // A real mem_done on the last allowed cycle wins over the timeout.
    timeout_hit = (TIMEOUT != 0) && busy &&
                  (wait_cnt_reg == WAIT_W'(TIMEOUT - 1)) && !bus.mem_done;
    done_evt    = busy && (bus.mem_done || timeout_hit);
    done_now    = done_evt ? grant_reg : '0;
    remaining   = pending & ~done_now;
    // Completion releases hold combinationally in the done cycle itself.
    hold_int    = rst && !initializing && (|remaining);
  end

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    mem_start_next   = 1'b0;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = timeout_err_reg | timeout_hit;
    // The slot ends (and served resets) whenever the pipeline is not held.
    served_next      = hold_int ? (served_reg | done_now) : '0;

    case (state_reg)
      IDLE: begin
        if (!initializing && (|pending)) begin
          state_next     = BUSY;
          grant_next     = pending_first;
          mem_start_next = 1'b1;
          wait_cnt_next  = '0;
        end
      end
      BUSY: begin
        if (wait_cnt_reg != {WAIT_W{1'b1}}) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
        if (done_evt) begin
          wait_cnt_next = '0;
          if (!initializing && (|remaining)) begin
            // Hand over directly to the next port, no idle bubble.
            grant_next     = remaining_first;
            mem_start_next = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      served_reg      <= '0;
      mem_start_reg   <= 1'b0;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      served_reg      <= served_next;
      mem_start_reg   <= mem_start_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.mem_start = mem_start_reg;
  assign bus.port_done = done_now;
  assign bus.hold      = hold_int;
  assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_mem_stall_arb.sv
// Directed self-checking bench for mem_stall_arb (NUM_PORTS=2, TIMEOUT=12).
// Inputs are driven 1 time unit after each rising edge ("start of cycle"),
// outputs are checked 2 units later, well away from any clock edge.
module tb_mem_stall_arb;

  logic clk = 1'b0;
  logic rst;
  logic initializing;
  logic timeout_err;
  int   checks   = 0;
  int   failures = 0;

  mem_stall_arb_if #(.NUM_PORTS(2)) bus();

  mem_stall_arb #(
    .NUM_PORTS(2),
    .WAIT_W   (4),
    .TIMEOUT  (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .initializing(initializing),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    initializing = 1'b0;
    bus.req      = 2'b00;
    bus.mem_done = 1'b0;
    cyc();
    cyc();
    #2;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_mem_start", 32'(bus.mem_start), 32'h0);
    chk("rst_hold", 32'(bus.hold), 32'h0);
    chk("rst_port_done", 32'(bus.port_done), 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);
    cyc();
    rst = 1'b1;
    cyc();

    // Single port: req at 0, mem_done at 3.
    bus.req = 2'b01; #2;
    chk("single_c0_hold", 32'(bus.hold), 32'h1);
    chk("single_c0_grant", 32'(bus.grant), 32'h0);
    cyc(); #2;
    chk("single_c1_grant", 32'(bus.grant), 32'h1);
    chk("single_c1_start", 32'(bus.mem_start), 32'h1);
    cyc(); #2;
    chk("single_c2_start", 32'(bus.mem_start), 32'h0);
    chk("single_c2_hold", 32'(bus.hold), 32'h1);
    cyc(); bus.mem_done = 1'b1; #2;
    chk("single_c3_port_done", 32'(bus.port_done), 32'h1);
    chk("single_c3_hold", 32'(bus.hold), 32'h0);
    cyc(); bus.mem_done = 1'b0; bus.req = 2'b00; #2;
    chk("single_c4_grant", 32'(bus.grant), 32'h0);
    chk("single_c4_port_done", 32'(bus.port_done), 32'h0);

    // Contention: req=11 at 0, mem_done at 2 and 4.
    cyc(); bus.req = 2'b11; #2;
    chk("cont_c0_hold", 32'(bus.hold), 32'h1);
    cyc(); #2;
    chk("cont_c1_grant", 32'(bus.grant), 32'h1);
    chk("cont_c1_start", 32'(bus.mem_start), 32'h1);
    cyc(); bus.mem_done = 1'b1; #2;
    chk("cont_c2_port_done", 32'(bus.port_done), 32'h1);
    chk("cont_c2_hold", 32'(bus.hold), 32'h1);
    cyc(); bus.mem_done = 1'b0; #2;
    chk("cont_c3_grant", 32'(bus.grant), 32'h2);
    chk("cont_c3_start", 32'(bus.mem_start), 32'h1);
    chk("cont_c3_hold", 32'(bus.hold), 32'h1);
    cyc(); bus.mem_done = 1'b1; #2;
    chk("cont_c4_grant", 32'(bus.grant), 32'h2);
    chk("cont_c4_start", 32'(bus.mem_start), 32'h0);
    chk("cont_c4_port_done", 32'(bus.port_done), 32'h2);
    chk("cont_c4_hold", 32'(bus.hold), 32'h0);
    // Both requests still up: served must have cleared, so hold rises again.
    cyc(); bus.mem_done = 1'b0; #2;
    chk("cont_c5_served_clear", 32'(bus.hold), 32'h1);
    chk("cont_c5_grant", 32'(bus.grant), 32'h0);
    bus.req = 2'b00; #1;
    chk("cont_c5_hold_drop", 32'(bus.hold), 32'h0);

    // mem_done while idle is ignored.
    cyc(); bus.mem_done = 1'b1; #2;
    chk("idle_done_port_done", 32'(bus.port_done), 32'h0);
    cyc(); bus.mem_done = 1'b0; #2;
    chk("idle_done_grant", 32'(bus.grant), 32'h0);
    chk("idle_done_start", 32'(bus.mem_start), 32'h0);

    // Priority only at grant time: port 0 arriving mid-access waits.
    cyc(); bus.req = 2'b10; #2;
    cyc(); bus.req = 2'b11; #2;
    chk("prio_c1_grant", 32'(bus.grant), 32'h2);
    cyc(); bus.mem_done = 1'b1; #2;
    chk("prio_c2_grant", 32'(bus.grant), 32'h2);
    chk("prio_c2_port_done", 32'(bus.port_done), 32'h2);
    chk("prio_c2_hold", 32'(bus.hold), 32'h1);
    cyc(); #2;
    chk("prio_c3_grant", 32'(bus.grant), 32'h1);
    chk("prio_c3_start", 32'(bus.mem_start), 32'h1);
    chk("prio_c3_port_done", 32'(bus.port_done), 32'h1);
    chk("prio_c3_hold", 32'(bus.hold), 32'h0);
    cyc(); bus.mem_done = 1'b0; bus.req = 2'b00; #2;
    chk("prio_c4_grant", 32'(bus.grant), 32'h0);

    // Flush: req drops while granted.
    cyc(); bus.req = 2'b01; #2;
    cyc(); bus.req = 2'b00; #2;
    chk("flush_c1_grant", 32'(bus.grant), 32'h1);
    chk("flush_c1_hold", 32'(bus.hold), 32'h0);
    cyc(); #2;
    chk("flush_c2_grant", 32'(bus.grant), 32'h1);
    cyc(); bus.mem_done = 1'b1; #2;
    chk("flush_c3_port_done", 32'(bus.port_done), 32'h1);
    cyc(); bus.mem_done = 1'b0; #2;
    chk("flush_c4_grant", 32'(bus.grant), 32'h0);
    chk("flush_c4_port_done", 32'(bus.port_done), 32'h0);
    cyc(); #2;
    chk("flush_c5_grant", 32'(bus.grant), 32'h0);

    // Initializing suppresses hold and grants.
    cyc(); initializing = 1'b1; bus.req = 2'b01; #2;
    chk("init_c0_hold", 32'(bus.hold), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); #2;
      chk("init_loop_grant", 32'(bus.grant), 32'h0);
      chk("init_loop_hold", 32'(bus.hold), 32'h0);
    end
    cyc(); initializing = 1'b0; #2;
    chk("init_k_hold", 32'(bus.hold), 32'h1);
    chk("init_k_grant", 32'(bus.grant), 32'h0);
    cyc(); #2;
    chk("init_k1_grant", 32'(bus.grant), 32'h1);
    chk("init_k1_start", 32'(bus.mem_start), 32'h1);
    bus.mem_done = 1'b1;
    cyc(); bus.mem_done = 1'b0; bus.req = 2'b00; #2;
    chk("init_end_grant", 32'(bus.grant), 32'h0);

    // Timeout: req=10 at 0, never done; forced completion at cycle 12.
    cyc(); bus.req = 2'b10; #2;
    for (int i = 1; i <= 11; i++) begin
      cyc(); #2;
      chk("to_wait_grant", 32'(bus.grant), 32'h2);
      chk("to_wait_port_done", 32'(bus.port_done), 32'h0);
      chk("to_wait_err", 32'(timeout_err), 32'h0);
    end
    cyc(); #2;
    chk("to_c12_port_done", 32'(bus.port_done), 32'h2);
    chk("to_c12_hold", 32'(bus.hold), 32'h0);
    chk("to_c12_err", 32'(timeout_err), 32'h0);
    bus.req = 2'b00;
    cyc(); #2;
    chk("to_c13_err", 32'(timeout_err), 32'h1);
    chk("to_c13_grant", 32'(bus.grant), 32'h0);
    // Later normal traffic leaves the sticky error set.
    cyc(); bus.req = 2'b01; #2;
    cyc(); bus.mem_done = 1'b1; #2;
    chk("to_after_port_done", 32'(bus.port_done), 32'h1);
    cyc(); bus.mem_done = 1'b0; bus.req = 2'b00; #2;
    chk("to_after_err", 32'(timeout_err), 32'h1);

    // Asynchronous reset mid-access.
    cyc(); bus.req = 2'b01; #2;
    cyc(); #2;
    chk("arst_pre_grant", 32'(bus.grant), 32'h1);
    rst = 1'b0; #1;
    chk("arst_grant", 32'(bus.grant), 32'h0);
    chk("arst_hold", 32'(bus.hold), 32'h0);
    chk("arst_err", 32'(timeout_err), 32'h0);
    chk("arst_start", 32'(bus.mem_start), 32'h0);
    cyc(); rst = 1'b1; #2;
    chk("arst_rel_hold", 32'(bus.hold), 32'h1);
    chk("arst_rel_grant", 32'(bus.grant), 32'h0);
    cyc(); #2;
    chk("arst_regrant", 32'(bus.grant), 32'h1);
    chk("arst_regrant_start", 32'(bus.mem_start), 32'h1);
    bus.mem_done = 1'b1;
    cyc(); bus.mem_done = 1'b0; bus.req = 2'b00; #2;
    chk("arst_end_grant", 32'(bus.grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
